// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: font ROM geometry and the font ROM arbiter state type.
package vga_pkg;

  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/font_rom_arbiter_rr_picker.sv
// Combinational one-hot round-robin select: the search starts one past rr_ptr and wraps.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: round-robin with burst locking, one-hot response routing after ROM_LAT.
// Optional build macro FONT_ARB_PRIO0_EN gives requester 0 strict, pre-emptive priority.
module font_rom_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = FONT_ADDR_W,
  parameter int DATA_W  = FONT_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] rr_gnt;
  logic [N_REQ-1:0] gnt_c;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             prio0_hit;
  logic             lock_ok;

  // Index 0 is the tag sampled at the grant edge; the last index drives rsp_valid.
  logic [N_REQ-1:0]  tag_q [ROM_LAT+1];
  logic [N_REQ-1:0]  tag_d [ROM_LAT+1];
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (rr_gnt)
  );

`ifdef FONT_ARB_PRIO0_EN
  assign prio0_hit = req[0];
  assign lock_ok   = (gnt_idx != '0);
`else
  assign prio0_hit = 1'b0;
  assign lock_ok   = 1'b1;
`endif

  // Grant selection
  always_comb begin
    gnt_c = '0;
    case (state_q)
      ARB: begin
        if (prio0_hit) gnt_c = {{(N_REQ-1){1'b0}}, 1'b1};
        else           gnt_c = rr_gnt;
      end
      LOCKED: begin
        if (prio0_hit) gnt_c = {{(N_REQ-1){1'b0}}, 1'b1};
        else           gnt_c[owner_q] = req[owner_q];
      end
      default: gnt_c = '0;
    endcase
  end

  always_comb begin
    gnt_idx  = '0;
    rom_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) gnt_idx = PTR_W'(i);
      rom_addr = rom_addr | (addr_in[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_c[i]}});
    end
  end

  assign gnt_any = |gnt_c;

  // FSM and round-robin pointer update
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) rr_ptr_d = gnt_idx;
    case (state_q)
      ARB: begin
        if (gnt_any && lock[gnt_idx] && lock_ok) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end
      end
      LOCKED: begin
        // A pre-empted owner keeps the lock; only its own last beat or a dropped req releases it.
        if (!req[owner_q])                             state_d = ARB;
        else if (gnt_c[owner_q] && !lock[owner_q])     state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Tag/data pipeline
  always_comb begin
    tag_d[0] = gnt_c;
    for (int k = 1; k <= ROM_LAT; k++) tag_d[k] = tag_q[k-1];
    rsp_data_d = (|tag_q[ROM_LAT-1]) ? rom_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      owner_q    <= '0;
      rr_ptr_q   <= PTR_W'(N_REQ - 1);
      rsp_data_q <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign gnt       = gnt_c;
  assign rsp_valid = tag_q[ROM_LAT];
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter with a response scoreboard and a behavioural 1-cycle ROM.
module tb_font_rom_arbiter;
  import vga_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, lock, gnt, rsp_valid;
  logic [N*AW-1:0] addr_in;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, rsp_data;
  logic [AW-1:0] a [N];

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] x);
    return (x == 11'h315) ? 8'h3C : (x[7:0] ^ 8'h5A);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_f(rom_addr);

  always_comb begin
    addr_in = '0;
    for (int i = 0; i < N; i++) addr_in[i*AW +: AW] = a[i];
  end

  font_rom_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .addr_in   (addr_in),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of req/lock, check the combinational grant, and book the expected response.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] eg,
                      input bit push = 1'b1);
    logic [AW-1:0] ea;
    exp_t          e;
    req  = r;
    lock = l;
    @(negedge clk);
    ea = '0;
    for (int i = 0; i < N; i++) if (eg[i]) ea = a[i];
    check("gnt", gnt, eg);
    check("rom_addr", rom_addr, ea);
    if (push && eg != '0) begin
      e.v   = eg;
      e.d   = rom_f(ea);
      e.due = cyc + LAT + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rsp_valid_in_reset", rsp_valid, 0);
      check("rsp_data_in_reset", rsp_data, 0);
    end else if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rsp_unexpected: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, e.v);
        check("rsp_data", rsp_data, e.d);
        check("rsp_cycle", cyc, e.due);
      end
    end else begin
      check("rsp_data_idle", rsp_data, 0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        fails++;
        $display("FAIL rsp_missing: got no rsp_valid expected %b (cycle %0d)", e.v, cyc);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    a[0] = 11'h0A3;
    a[1] = 11'h315;
    a[2] = 11'h5E7;
    a[3] = 11'h7FF;
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_gnt", gnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single requester, ROM returns 0x3C
    step(4'b0010, 4'b0000, 4'b0010);
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);

    // Reset one cycle after a grant discards the response
    step(4'b0001, 4'b0000, 4'b0001, 1'b0);
    req = '0;
    rst = 1'b1;
    #1;
    check("async_rsp_valid", rsp_valid, 0);
    check("async_rsp_data", rsp_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(4'b0000, 4'b0000, 4'b0000);

    // All requesters held high: 0,1,2,3,0,1
    step(4'b1111, 4'b0000, 4'b0001);
    step(4'b1111, 4'b0000, 4'b0010);
    step(4'b1111, 4'b0000, 4'b0100);
    step(4'b1111, 4'b0000, 4'b1000);
    step(4'b1111, 4'b0000, 4'b0001);
    step(4'b1111, 4'b0000, 4'b0010);

    // Lock burst by requester 2 while 0 and 3 wait
    step(4'b1101, 4'b0100, 4'b0100);
    step(4'b1101, 4'b0100, 4'b0100);
    step(4'b1101, 4'b0100, 4'b0100);
    step(4'b1101, 4'b0000, 4'b0100);
    step(4'b1001, 4'b0000, 4'b1000);
    step(4'b0001, 4'b0000, 4'b0001);

    // Owner drops req while locked
    step(4'b0010, 4'b0010, 4'b0010);
    step(4'b1000, 4'b0000, 4'b0000);
    step(4'b1000, 4'b0000, 4'b1000);

`ifdef FONT_ARB_PRIO0_EN
    // Requester 0 pre-empts a locked owner without breaking the lock
    step(4'b0010, 4'b0010, 4'b0010);
    step(4'b0011, 4'b0010, 4'b0001);
    step(4'b0010, 4'b0010, 4'b0010);
    step(4'b0010, 4'b0000, 4'b0010);
`endif

    repeat (4) step(4'b0000, 4'b0000, 4'b0000);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
# font_rom_arbiter

Shares the single synchronous character/font ROM (address = {char_code[6:0], line[3:0]}) between several text-overlay requesters in the VGA pipeline, such as frame lettering, score text and menu text. It grants at most one request per cycle using round-robin with optional burst locking, drives the ROM address, and routes the returned font row back to the owning requester with a one-hot response strobe.

## Interface
- N_REQ, 4: number of requesters (2..8)
- ADDR_W, 11: ROM address width
- DATA_W, 8: font row width (pixels per glyph line)
- ROM_LAT, 1: ROM read latency in cycles (1..3)
- clk  in  1  system/pixel clock
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  per-requester request, held until granted
- lock  in  N_REQ  per-requester burst lock, sampled with req
- addr_in  in  N_REQ*ADDR_W  flat address bus, requester i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
- rom_addr  out  ADDR_W  ROM address, combinational mux of granted addr_in, 0 when idle
- rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr
- rsp_valid  out  N_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_W  font row, registered, 0 when no rsp_valid

## Operation
- States: ARB (round-robin) and LOCKED (owner fixed).
- ARB: search order starts at rr_ptr+1 mod N_REQ; first requester with req=1 wins. No req: gnt=0, rom_addr=0.
- On every grant to i: rr_ptr <= i.
- ARB -> LOCKED: grant to i with lock[i]=1; owner <= i.
- LOCKED: only owner can be granted. Other requests stall. gnt[owner]=req[owner].
- LOCKED -> ARB: a cycle where req[owner]=0, or owner is granted with lock[owner]=0. That last beat is still granted. Re-arbitration starts the next cycle.
- A requester samples gnt. On gnt=1 it may present a new req/addr the next cycle, which allows back-to-back beats.
- Tag pipeline: ROM_LAT+1 stages of one-hot gnt. rsp_valid = last stage. rsp_data register loads rom_data when the tag at stage ROM_LAT is nonzero, else loads 0.
- Throughput: one grant per cycle. Responses are returned in grant order.

## Timing
- Grant cycle t: gnt and rom_addr valid in t.
- rsp_valid/rsp_data valid at cycle t+ROM_LAT+1, for exactly one cycle per grant.
- Reset values: rr_ptr=N_REQ-1, so requester 0 is first. State=ARB. owner=0. Tag pipeline=0. rsp_valid=0. rsp_data=0.
- Reset mid-operation: in-flight responses are discarded. No rsp_valid appears in the first ROM_LAT+1 cycles after release unless new grants are made.
- Simultaneous requests: exactly one gnt bit is set. Losers keep req high and are served within N_REQ-1 grants, unless locks apply.
- lock with req=0 is ignored.
- rr_ptr wraps from N_REQ-1 to 0.

## Configuration
- FONT_ARB_PRIO0_EN defined:
  - Requester 0 has strict priority over round-robin in ARB.
  - It also pre-empts a LOCKED owner: owner's gnt=0 that cycle, state stays LOCKED.
  - Requester 0 never takes a lock; its lock input is ignored.
  - This is for the timing-critical on-screen frame lettering.
- Undefined: pure round-robin as above; requester 0 is ordinary.

## Structure
- vga_pkg gains:
  - FONT_ADDR_W=11
  - FONT_DATA_W=8
  - typedef arb_state_t {ARB, LOCKED}
- Sub-module rr_picker: combinational N_REQ one-hot round-robin select with inputs req and rr_ptr. Reused in ARB state.
- Tag/data pipeline stays inline in font_rom_arbiter.

## Test plan
- Single requester: req[1]=1, addr_in[1]=0x315, ROM returns 0x3C.
  - gnt=0010 and rom_addr=0x315 same cycle.
  - rsp_valid=0010, rsp_data=0x3C at t+2 (ROM_LAT=1).
- All four req held high, no lock, after reset:
  - Grants cycle 0,1,2,3,0,1… one per cycle.
  - rsp_valid follows the same order two cycles later.
- Lock burst: req[2]=1, lock[2]=1 for 3 beats then lock[2]=0, while req[0]=req[3]=1.
  - Grants 2,2,2,2 (last beat unlocked), then 3, then 0.
- Owner drops req while LOCKED: next cycle state=ARB and another pending requester is granted.
- Reset asserted one cycle after a grant: rsp_valid stays 0 through and after reset. Outputs are 0 asynchronously.
- With FONT_ARB_PRIO0_EN: requester 1 locked; req[0] pulses.
  - gnt=0001 for that cycle, gnt[1] resumes the next cycle, state remains LOCKED.
